pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline stall/flush sequencer for the 5-stage WISC-SP13 core. It sits beside the forwarding unit and decides, every cycle, whether each pipeline register advances, holds, bubbles or flushes. It covers load-use hazards, branch-after-load hazards in decode, multi-cycle instruction/data memory waits, taken-branch flushes and HALT draining. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- DRAIN_CYCLES, 3, non-stalled cycles from HALT leaving decode until `halted` asserts (HALT moves DX→XM→MW→retire).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  core clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- RegisterRs_fd  in  3  Rs of the instruction in decode.
- RegisterRt_fd  in  3  Rt of the instruction in decode.
- Rs_used_fd  in  1  decode instruction reads Rs.
- Rt_used_fd  in  1  decode instruction reads Rt.
- is_branch_fd  in  1  decode instruction is a branch or JR/JALR that resolves Rs in decode.
- halt_fd  in  1  decode instruction is HALT.
- branch_taken  in  1  decode-stage branch/jump resolved as redirecting the PC.
- MemRead_dx, RegWrite_dx  in  1 each  control signals of the instruction in EX.
- RegisterRd_dx  in  3  destination register of the instruction in EX.
- MemRead_xm, RegWrite_xm  in  1 each  control signals of the instruction in MEM.
- RegisterRd_xm  in  3  destination register of the instruction in MEM.
- imem_stall  in  1  instruction memory busy; fetch data is not valid.
- dmem_stall  in  1  data memory busy; the MEM stage cannot complete.
- pc_write  out  1  PC may update.
- fd_write  out  1  FD register may load.
- fd_flush  out  1  FD register loads a NOP.
- dx_bubble  out  1  DX register loads a NOP (control bits zeroed).
- pipe_freeze  out  1  DX, XM and MW all hold.
- halted  out  1  core has halted; the signal is sticky until `rst`.
- stall_cycles  out  CNT_W  saturating count of RUN-state cycles with `pc_write`=0.
- flush_count  out  CNT_W  saturating count of branch-flush cycles.

## Operation
- Hazard terms, combinational:
  - ld_use = MemRead_dx & RegWrite_dx & ((Rs_used_fd & RegisterRd_dx==RegisterRs_fd) | (Rt_used_fd & RegisterRd_dx==RegisterRt_fd)).
  - br_dep = is_branch_fd & MemRead_xm & RegWrite_xm & RegisterRd_xm==RegisterRs_fd.
  - A branch that follows a load directly therefore stalls 2 cycles: ld_use fires, then br_dep fires, then the value forwards from MW.
  - Register 0 is not excluded.
- FSM states: RUN, DRAIN, HALTED. Reset enters RUN.
- Default outputs in RUN: pc_write=1, fd_write=1, fd_flush=0, dx_bubble=0, pipe_freeze=0.
- RUN applies the following rules in strict priority order:
  1. dmem_stall: pipe_freeze=1, pc_write=0, fd_write=0, dx_bubble=0. Everything holds.
  2. ld_use | br_dep: pc_write=0, fd_write=0, dx_bubble=1.
  3. imem_stall: pc_write=0, fd_write=0, dx_bubble=1. The branch held in decode re-resolves later.
  4. halt_fd: pc_write=0, fd_flush=1. HALT advances into DX. Next state is DRAIN with drain_cnt=DRAIN_CYCLES-1.
  5. branch_taken: pc_write=1, fd_flush=1, flush_count++.
- DRAIN:
  - Outputs: pc_write=0, fd_write=0, fd_flush=1.
  - dmem_stall in DRAIN: pipe_freeze=1 and drain_cnt holds.
  - Otherwise drain_cnt decrements. At 0 the next state is HALTED.
  - Fetch-side inputs (imem_stall, branch_taken, ld_use, br_dep, halt_fd) are ignored.
- HALTED:
  - Outputs: halted=1, pc_write=0, fd_write=0, dx_bubble=1, pipe_freeze=1.
  - All inputs are ignored. Only `rst` exits.
- Counters:
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
  - stall_cycles counts only in RUN.
  - flush_count counts only rule 5. A halt flush does not count.

## Timing
- All control outputs are Mealy: combinational from state and same-cycle inputs, with zero latency.
- halted, the FSM state, drain_cnt and the counters are registered.
- Reset values, in the cycle after `rst` with idle inputs: state=RUN, pc_write=1, fd_write=1, fd_flush=0, dx_bubble=0, pipe_freeze=0, halted=0, stall_cycles=0, flush_count=0.
- While `rst`=1, outputs take their reset values.
- `rst` in DRAIN or HALTED returns to RUN on the next edge.
- Simultaneous events resolve by the priority order above. Example: dmem_stall with branch_taken gives a freeze with no flush, and flush_count is unchanged.
- halted asserts on the edge that ends the DRAIN_CYCLES-th non-frozen DRAIN cycle. With no stalls, that is 4 cycles after the halt_fd cycle.

## Test plan
- Load-use: LD R3 in EX with an ADD reading R3 in decode. Expect 1 cycle of pc_write=0, fd_write=0, dx_bubble=1; next cycle all defaults; stall_cycles=1.
- Branch after load: LD R2 then BEQZ R2. Expect 2 consecutive stall cycles (ld_use, then br_dep); on the third cycle branch_taken=1 gives fd_flush=1 and flush_count=1.
- Data-memory wait: dmem_stall held 5 cycles while ld_use=1 and branch_taken=1. Expect pipe_freeze=1 for 5 cycles, then the ld_use bubble; flush_count unchanged during the freeze.
- HALT: halt_fd=1 with no stalls. Expect DRAIN for 3 cycles and halted=1 on cycle 4. Repeat with dmem_stall for 2 cycles inside DRAIN: halted is delayed by exactly 2 cycles.
- Counter saturation: preload via a long imem_stall (CNT_W=4 build, 20 cycles). Expect stall_cycles stops at 15.
- Reset mid-DRAIN and in HALTED: assert `rst` for 1 cycle. Expect all reset values on the next cycle and halted=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the WISC-SP13 pipeline datapath and the stall/flush
// sequencer. The datapath side is the master; pipe_ctrl is the slave.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 16
) ();

    // Decode-stage instruction
    logic [2:0]       RegisterRs_fd;
    logic [2:0]       RegisterRt_fd;
    logic             Rs_used_fd;
    logic             Rt_used_fd;
    logic             is_branch_fd;
    logic             halt_fd;
    logic             branch_taken;

    // Execute-stage instruction
    logic             MemRead_dx;
    logic             RegWrite_dx;
    logic [2:0]       RegisterRd_dx;

    // Memory-stage instruction
    logic             MemRead_xm;
    logic             RegWrite_xm;
    logic [2:0]       RegisterRd_xm;

    // Memory wait requests
    logic             imem_stall;
    logic             dmem_stall;

    // Pipeline register controls
    logic             pc_write;
    logic             fd_write;
    logic             fd_flush;
    logic             dx_bubble;
    logic             pipe_freeze;
    logic             halted;

    // Performance counters
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output RegisterRs_fd, RegisterRt_fd, Rs_used_fd, Rt_used_fd,
               is_branch_fd, halt_fd, branch_taken,
               MemRead_dx, RegWrite_dx, RegisterRd_dx,
               MemRead_xm, RegWrite_xm, RegisterRd_xm,
               imem_stall, dmem_stall,
        input  pc_write, fd_write, fd_flush, dx_bubble, pipe_freeze, halted,
               stall_cycles, flush_count
    );

    modport slave (
        input  RegisterRs_fd, RegisterRt_fd, Rs_used_fd, Rt_used_fd,
               is_branch_fd, halt_fd, branch_taken,
               MemRead_dx, RegWrite_dx, RegisterRd_dx,
               MemRead_xm, RegWrite_xm, RegisterRd_xm,
               imem_stall, dmem_stall,
        output pc_write, fd_write, fd_flush, dx_bubble, pipe_freeze, halted,
               stall_cycles, flush_count
    );

endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage WISC-SP13 core.
// Decides each cycle whether PC/FD/DX/XM/MW advance, hold, bubble or flush,
// drains HALT to retirement and keeps saturating stall/flush counters.
// All pipeline controls are Mealy; state, drain counter and counters are registered.
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input logic         clk,
    input logic         rst,
    pipe_ctrl_if.slave  bus
);

    // Wide enough to hold DRAIN_CYCLES-1
    localparam int unsigned DrainW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DrainW-1:0] DrainInit = DrainW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e            stateQ, stateD;
    logic [DrainW-1:0] drainCntQ, drainCntD;
    logic [CNT_W-1:0]  stallCntQ, flushCntQ;

    logic ldUse;
    logic brDep;
    logic pcWrite;
    logic fdWrite;
    logic fdFlush;
    logic dxBubble;
    logic pipeFreeze;
    logic countStall;
    logic countFlush;

    // Hazard detection; register 0 is deliberately treated like any other register
    always_comb begin
        ldUse = bus.MemRead_dx & bus.RegWrite_dx &
                ((bus.Rs_used_fd & (bus.RegisterRd_dx == bus.RegisterRs_fd)) |
                 (bus.Rt_used_fd & (bus.RegisterRd_dx == bus.RegisterRt_fd)));
        brDep = bus.is_branch_fd & bus.MemRead_xm & bus.RegWrite_xm &
                (bus.RegisterRd_xm == bus.RegisterRs_fd);
    end

    // Next-state, drain countdown and Mealy pipeline controls
    always_comb begin
        stateD     = stateQ;
        drainCntD  = drainCntQ;
        pcWrite    = 1'b1;
        fdWrite    = 1'b1;
        fdFlush    = 1'b0;
        dxBubble   = 1'b0;
        pipeFreeze = 1'b0;
        countStall = 1'b0;
        countFlush = 1'b0;

        if (!rst) begin
            unique case (stateQ)
                StRun: begin
                    if (bus.dmem_stall) begin
                        // MEM cannot complete: hold the whole pipe, no bubble
                        pipeFreeze = 1'b1;
                        pcWrite    = 1'b0;
                        fdWrite    = 1'b0;
                    end else if (ldUse || brDep) begin
                        pcWrite  = 1'b0;
                        fdWrite  = 1'b0;
                        dxBubble = 1'b1;
                    end else if (bus.imem_stall) begin
                        // Decode re-resolves its branch once fetch catches up
                        pcWrite  = 1'b0;
                        fdWrite  = 1'b0;
                        dxBubble = 1'b1;
                    end else if (bus.halt_fd) begin
                        // HALT moves into DX while FD is squashed behind it
                        pcWrite   = 1'b0;
                        fdFlush   = 1'b1;
                        stateD    = StDrain;
                        drainCntD = DrainInit;
                    end else if (bus.branch_taken) begin
                        fdFlush    = 1'b1;
                        countFlush = 1'b1;
                    end
                    countStall = ~pcWrite;
                end
                StDrain: begin
                    pcWrite = 1'b0;
                    fdWrite = 1'b0;
                    fdFlush = 1'b1;
                    if (bus.dmem_stall) begin
                        pipeFreeze = 1'b1;
                    end else if (drainCntQ == '0) begin
                        stateD = StHalted;
                    end else begin
                        drainCntD = drainCntQ - 1'b1;
                    end
                end
                StHalted: begin
                    pcWrite    = 1'b0;
                    fdWrite    = 1'b0;
                    dxBubble   = 1'b1;
                    pipeFreeze = 1'b1;
                end
                default: begin
                    stateD = StRun;
                end
            endcase
        end
    end

    // State and drain counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= StRun;
            drainCntQ <= '0;
        end else begin
            stateQ    <= stateD;
            drainCntQ <= drainCntD;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (countStall && (stallCntQ != '1)) begin
                stallCntQ <= stallCntQ + 1'b1;
            end
            if (countFlush && (flushCntQ != '1)) begin
                flushCntQ <= flushCntQ + 1'b1;
            end
        end
    end

    // Output drive
    always_comb begin
        bus.pc_write     = pcWrite;
        bus.fd_write     = fdWrite;
        bus.fd_flush     = fdFlush;
        bus.dx_bubble    = dxBubble;
        bus.pipe_freeze  = pipeFreeze;
        bus.halted       = (stateQ == StHalted);
        bus.stall_cycles = stallCntQ;
        bus.flush_count  = flushCntQ;
    end

    // Once halted, only reset leaves HALTED
    haltedSticky: assert property (@(posedge clk) disable iff (rst)
        (stateQ == StHalted) |=> (stateQ == StHalted));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hand-computed control vectors per cycle plus
// counter values, built with CNT_W=4 so saturation is reachable quickly.
module tb_pipe_ctrl;

    localparam int unsigned CntW = 4;

    // {pc_write, fd_write, fd_flush, dx_bubble, pipe_freeze, halted}
    localparam logic [5:0] OutRun      = 6'b110000;
    localparam logic [5:0] OutStall    = 6'b000100;
    localparam logic [5:0] OutFreeze   = 6'b000010;
    localparam logic [5:0] OutFlush    = 6'b111000;
    localparam logic [5:0] OutHaltIn   = 6'b011000;
    localparam logic [5:0] OutDrain    = 6'b001000;
    localparam logic [5:0] OutDrainFrz = 6'b001010;
    localparam logic [5:0] OutHalted   = 6'b000111;

    logic clk;
    logic rst;
    int   vecCount;
    int   missCount;

    pipe_ctrl_if #(.CNT_W(CntW)) bus ();

    pipe_ctrl #(
        .DRAIN_CYCLES (3),
        .CNT_W        (CntW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        vecCount++;
        if (got !== want) begin
            missCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic idleInputs();
        bus.RegisterRs_fd = 3'd0;
        bus.RegisterRt_fd = 3'd0;
        bus.Rs_used_fd    = 1'b0;
        bus.Rt_used_fd    = 1'b0;
        bus.is_branch_fd  = 1'b0;
        bus.halt_fd       = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.MemRead_dx    = 1'b0;
        bus.RegWrite_dx   = 1'b0;
        bus.RegisterRd_dx = 3'd0;
        bus.MemRead_xm    = 1'b0;
        bus.RegWrite_xm   = 1'b0;
        bus.RegisterRd_xm = 3'd0;
        bus.imem_stall    = 1'b0;
        bus.dmem_stall    = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Sample on the falling edge of the current cycle
    task automatic checkOuts(input string tag, input logic [5:0] want);
        @(negedge clk);
        checkVal(tag, {26'd0, bus.pc_write, bus.fd_write, bus.fd_flush, bus.dx_bubble,
                       bus.pipe_freeze, bus.halted}, {26'd0, want});
    endtask

    task automatic checkCnts(input string tag, input int stalls, input int flushes);
        @(negedge clk);
        checkVal({tag, "_stall"}, {28'd0, bus.stall_cycles}, stalls);
        checkVal({tag, "_flush"}, {28'd0, bus.flush_count}, flushes);
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic loadUse(input logic [2:0] rd, input logic [2:0] rs);
        bus.MemRead_dx    = 1'b1;
        bus.RegWrite_dx   = 1'b1;
        bus.RegisterRd_dx = rd;
        bus.RegisterRs_fd = rs;
        bus.Rs_used_fd    = 1'b1;
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        rst       = 1'b1;
        idleInputs();

        // Reset state
        doReset();
        checkOuts("reset_outs", OutRun);
        checkCnts("reset", 0, 0);
        nextCycle();

        // Load-use on Rs, then clear
        loadUse(3'd3, 3'd3);
        checkOuts("lduse_rs", OutStall);
        nextCycle();
        idleInputs();
        checkOuts("lduse_after", OutRun);
        checkCnts("lduse", 1, 0);
        nextCycle();

        // Load-use on Rt with register 0
        bus.MemRead_dx    = 1'b1;
        bus.RegWrite_dx   = 1'b1;
        bus.RegisterRd_dx = 3'd0;
        bus.RegisterRt_fd = 3'd0;
        bus.Rt_used_fd    = 1'b1;
        bus.RegisterRs_fd = 3'd5;
        checkOuts("lduse_rt_r0", OutStall);
        nextCycle();
        // Same match but Rt not used: no hazard
        bus.Rt_used_fd = 1'b0;
        checkOuts("no_use", OutRun);
        nextCycle();
        idleInputs();

        // Branch after load: ld_use, then br_dep, then taken branch flushes
        doReset();
        loadUse(3'd2, 3'd2);
        bus.is_branch_fd = 1'b1;
        checkOuts("brld_c1", OutStall);
        nextCycle();
        bus.MemRead_dx    = 1'b0;
        bus.RegWrite_dx   = 1'b0;
        bus.MemRead_xm    = 1'b1;
        bus.RegWrite_xm   = 1'b1;
        bus.RegisterRd_xm = 3'd2;
        checkOuts("brld_c2", OutStall);
        nextCycle();
        bus.MemRead_xm   = 1'b0;
        bus.RegWrite_xm  = 1'b0;
        bus.branch_taken = 1'b1;
        checkOuts("brld_c3", OutFlush);
        nextCycle();
        idleInputs();
        checkCnts("brld", 2, 1);
        nextCycle();

        // Data-memory wait beats load-use and taken branch
        doReset();
        loadUse(3'd4, 3'd4);
        bus.branch_taken = 1'b1;
        bus.dmem_stall   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOuts($sformatf("dmem_frz%0d", i), OutFreeze);
            nextCycle();
        end
        bus.dmem_stall = 1'b0;
        checkOuts("dmem_then_lduse", OutStall);
        nextCycle();
        idleInputs();
        checkCnts("dmem", 6, 0);
        nextCycle();

        // imem stall outranks a taken branch
        bus.imem_stall   = 1'b1;
        bus.branch_taken = 1'b1;
        checkOuts("imem_br", OutStall);
        nextCycle();
        idleInputs();
        checkCnts("imem_br", 7, 0);
        nextCycle();

        // HALT with no stalls; fetch-side inputs ignored in DRAIN and HALTED
        doReset();
        bus.halt_fd = 1'b1;
        checkOuts("halt_c0", OutHaltIn);
        nextCycle();
        bus.halt_fd      = 1'b0;
        bus.imem_stall   = 1'b1;
        bus.branch_taken = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            checkOuts($sformatf("drain_c%0d", i), OutDrain);
            nextCycle();
        end
        checkOuts("halted_c4", OutHalted);
        nextCycle();
        bus.halt_fd = 1'b1;
        checkOuts("halted_c5", OutHalted);
        checkCnts("halt", 1, 0);
        nextCycle();

        // Reset in HALTED
        idleInputs();
        rst = 1'b1;
        checkOuts("rst_held", OutRun & 6'b111110 | {5'd0, bus.halted});
        nextCycle();
        rst = 1'b0;
        checkOuts("rst_from_halted", OutRun);
        checkCnts("rst_halted", 0, 0);
        nextCycle();

        // HALT with two dmem stalls inside DRAIN: halted two cycles later
        bus.halt_fd = 1'b1;
        checkOuts("halt2_c0", OutHaltIn);
        nextCycle();
        bus.halt_fd = 1'b0;
        checkOuts("halt2_c1", OutDrain);
        nextCycle();
        bus.dmem_stall = 1'b1;
        checkOuts("halt2_c2", OutDrainFrz);
        nextCycle();
        checkOuts("halt2_c3", OutDrainFrz);
        nextCycle();
        bus.dmem_stall = 1'b0;
        checkOuts("halt2_c4", OutDrain);
        nextCycle();
        checkOuts("halt2_c5", OutDrain);
        nextCycle();
        checkOuts("halt2_c6", OutHalted);
        nextCycle();

        // Reset mid-DRAIN, then no spurious halt afterwards
        doReset();
        bus.halt_fd = 1'b1;
        nextCycle();
        bus.halt_fd = 1'b0;
        checkOuts("middrain", OutDrain);
        nextCycle();
        doReset();
        checkOuts("rst_from_drain", OutRun);
        checkCnts("rst_drain", 0, 0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
        end
        checkOuts("no_halt_after_rst", OutRun);
        nextCycle();

        // Counter saturation at 2^CNT_W-1 with 20 imem stall cycles
        doReset();
        bus.imem_stall = 1'b1;
        checkOuts("sat_first", OutStall);
        for (int i = 0; i < 20; i++) begin
            nextCycle();
        end
        idleInputs();
        checkCnts("sat", 15, 0);
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
